// File: rtl/psram_pkg.sv
// Shared definitions for the QSPI PSRAM device model: command opcodes,
// synchroniser depth and the transaction state encoding.
package psram_pkg;

    localparam logic [7:0]  CMD_QREAD   = 8'hEB;
    localparam logic [7:0]  CMD_QWRITE  = 8'h38;
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } psram_state_e;

endpackage

// File: rtl/psram_edge_sync.sv
// Brings the asynchronous QSPI pins into the system clock domain.
// Ports:
//   clk_i, rst_ni        system clock, async active-low reset
//   sck_i, ce_n_i, din_i raw serial clock, chip enable, data lines
//   ce_n_o, din_o        synchronised chip enable and data
//   sck_rise_o/_fall_o   one-clk pulses on synchronised sck edges
//   ce_rise_o            one-clk pulse when synchronised ce_n deasserts
module psram_edge_sync
    import psram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sck_i,
    input  logic       ce_n_i,
    input  logic [3:0] din_i,
    output logic       ce_n_o,
    output logic [3:0] din_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       ce_rise_o
);

    logic [SYNC_STAGES-1:0]      sck_q;
    logic [SYNC_STAGES-1:0]      ce_q;
    logic [SYNC_STAGES-1:0][3:0] din_q;
    logic                        sck_prev_q;
    logic                        ce_prev_q;

    // din goes through the same depth as sck so data and edge stay aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q      <= '0;
            ce_q       <= '1;
            din_q      <= '0;
            sck_prev_q <= 1'b0;
            ce_prev_q  <= 1'b1;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            ce_q       <= {ce_q[SYNC_STAGES-2:0], ce_n_i};
            din_q      <= {din_q[SYNC_STAGES-2:0], din_i};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
            ce_prev_q  <= ce_q[SYNC_STAGES-1];
        end
    end

    assign ce_n_o     = ce_q[SYNC_STAGES-1];
    assign din_o      = din_q[SYNC_STAGES-1];
    assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_q[SYNC_STAGES-1] & sck_prev_q;
    assign ce_rise_o  = ce_q[SYNC_STAGES-1] & ~ce_prev_q;

endmodule

// File: rtl/psram_qspi_dev.sv
// QSPI PSRAM device model: oversamples the serial bus, decodes quad read
// (0xEB) and quad write (0x38) and serves bytes from an internal array.
// Ports:
//   clk, resetn          system clock, async active-low reset
//   qspi_sck, qspi_ce_n  serial clock (mode 0), chip enable (active low)
//   qspi_din             sampled dio lines
//   qspi_dout            driven dio values
//   qspi_douten          per-line output enable
module psram_qspi_dev
    import psram_pkg::*;
#(
    parameter int unsigned MEM_AW = 22,
    parameter int unsigned DUMMY  = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       qspi_sck,
    input  logic       qspi_ce_n,
    input  logic [3:0] qspi_din,
    output logic [3:0] qspi_dout,
    output logic [3:0] qspi_douten
);

    localparam int unsigned CNT_W = 8;

    logic       ce_n_s;
    logic [3:0] din_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       ce_rise;

    psram_edge_sync u_sync (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .sck_i      (qspi_sck),
        .ce_n_i     (qspi_ce_n),
        .din_i      (qspi_din),
        .ce_n_o     (ce_n_s),
        .din_o      (din_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .ce_rise_o  (ce_rise)
    );

    psram_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       cmd_q;
    logic [23:0]      addr_q;
    logic [3:0]       whi_q;     // high nibble of the write byte in flight
    logic [3:0]       rlo_q;     // low nibble of the byte being read out
    logic             phase_q;   // 0: high nibble next, 1: low nibble next
    logic [3:0]       dout_q;
    logic [3:0]       douten_q;

    logic [7:0] mem [2**MEM_AW];

    logic [7:0] cmd_d;
    logic [7:0] rd_data;
    logic       wr_fire;

    assign cmd_d   = {cmd_q[6:0], din_s[0]};
    assign rd_data = mem[addr_q[MEM_AW-1:0]];
    // Only a completed byte is committed; an abort or reset before the low
    // nibble leaves the array untouched.
    assign wr_fire = resetn && !ce_n_s && sck_rise && (state_q == S_WDATA) && phase_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[addr_q[MEM_AW-1:0]] <= {whi_q, din_s};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            whi_q    <= '0;
            rlo_q    <= '0;
            phase_q  <= 1'b0;
            dout_q   <= '0;
            douten_q <= '0;
        end else if (ce_n_s || ce_rise) begin
            // Deselect has priority over any coincident sck edge.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            dout_q   <= '0;
            douten_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_CMD;
                    cnt_q   <= '0;
                end
                S_CMD: if (sck_rise) begin
                    cmd_q <= cmd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_q   <= '0;
                        state_q <= (cmd_d == CMD_QREAD || cmd_d == CMD_QWRITE) ? S_ADDR : S_IGNORE;
                    end
                end
                S_ADDR: if (sck_rise) begin
                    addr_q <= {addr_q[19:0], din_s};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(5)) begin
                        phase_q <= 1'b0;
                        cnt_q   <= CNT_W'(DUMMY);
                        if (cmd_q == CMD_QWRITE) begin
                            state_q <= S_WDATA;
                        end else if (DUMMY == 0) begin
                            state_q <= S_RDATA;
                        end else begin
                            state_q <= S_DUMMY;
                        end
                    end
                end
                S_DUMMY: if (sck_rise) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RDATA;
                    end
                end
                S_RDATA: if (sck_fall) begin
                    douten_q <= '1;
                    if (!phase_q) begin
                        dout_q  <= rd_data[7:4];
                        rlo_q   <= rd_data[3:0];
                        phase_q <= 1'b1;
                    end else begin
                        dout_q  <= rlo_q;
                        addr_q  <= addr_q + 24'd1;
                        phase_q <= 1'b0;
                    end
                end
                S_WDATA: if (sck_rise) begin
                    if (!phase_q) begin
                        whi_q   <= din_s;
                        phase_q <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + 24'd1;
                        phase_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign qspi_dout   = dout_q;
    assign qspi_douten = douten_q;

endmodule

// File: tb/tb_psram_qspi_dev.sv
module tb_psram_qspi_dev;
    import psram_pkg::*;

    localparam int HALF = 60;   // sck half period: 6 system clocks

    logic       clk = 1'b0;
    logic       resetn;
    logic       qspi_sck;
    logic       qspi_ce_n;
    logic [3:0] qspi_din;
    logic [3:0] qspi_dout;
    logic [3:0] qspi_douten;
    logic [3:0] m_dio;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    // Resolved dio bus: device drives where enabled, master elsewhere.
    assign qspi_din = (qspi_douten & qspi_dout) | (~qspi_douten & m_dio);

    psram_qspi_dev #(
        .MEM_AW (22),
        .DUMMY  (6)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .qspi_sck    (qspi_sck),
        .qspi_ce_n   (qspi_ce_n),
        .qspi_din    (qspi_din),
        .qspi_dout   (qspi_dout),
        .qspi_douten (qspi_douten)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b[7:4]);
        exp_q.push_back(b[3:0]);
    endtask

    // One sck cycle: drive v while low, sample the bus just after the rise.
    task automatic nib(input logic [3:0] v, input logic [3:0] en_exp, input string tag,
                       output logic [3:0] smp);
        m_dio = v;
        #HALF;
        qspi_sck = 1'b1;
        #1;
        smp = qspi_din;
        chk({tag, "_en"}, qspi_douten, en_exp);
        #(HALF - 1);
        qspi_sck = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [3:0] s;
        qspi_ce_n = 1'b0;
        for (int i = 7; i >= 0; i--) nib({3'b000, cmd[i]}, 4'h0, "cmd", s);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4], 4'h0, "addr", s);
    endtask

    task automatic txn_end();
        m_dio = 4'h0;
        #HALF;
        qspi_ce_n = 1'b1;
        #100;
        chk("deselect_en", qspi_douten, 4'h0);
    endtask

    task automatic qwrite(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0] s;
        hdr(CMD_QWRITE, a);
        nib(b0[7:4], 4'h0, "wr", s);
        nib(b0[3:0], 4'h0, "wr", s);
        nib(b1[7:4], 4'h0, "wr", s);
        nib(b1[3:0], 4'h0, "wr", s);
        txn_end();
    endtask

    task automatic read_nibs(input int n);
        logic [3:0] s;
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            nib(4'h0, 4'hF, "rd", s);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 4'h1, 4'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", s, e);
            end
        end
    endtask

    task automatic dummy_phase();
        logic [3:0] s;
        for (int i = 0; i < 6; i++) nib(4'h0, 4'h0, "dummy", s);
    endtask

    task automatic qread(input logic [23:0] a, input int n);
        hdr(CMD_QREAD, a);
        dummy_phase();
        read_nibs(n);
        txn_end();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        logic [3:0] s;
        resetn    = 1'b0;
        qspi_sck  = 1'b0;
        qspi_ce_n = 1'b1;
        m_dio     = 4'h0;
        #100;
        resetn = 1'b1;
        #100;

        // 1: reset while idle
        resetn = 1'b0;
        #1;
        chk("rst_douten", qspi_douten, 4'h0);
        chk("rst_dout", qspi_dout, 4'h0);
        chk("rst_state", {1'b0, dut.state_q}, {1'b0, S_IDLE});
        #50;
        resetn = 1'b1;
        #50;
        chk("rel_douten", qspi_douten, 4'h0);
        chk("rel_dout", qspi_dout, 4'h0);

        // 2/3: write then read back
        qwrite(24'h000010, 8'hA5, 8'h3C);
        push_byte(8'hA5);
        push_byte(8'h3C);
        qread(24'h000010, 4);

        // 4: address wrap at the top of the array
        qwrite(24'h3FFFFF, 8'h11, 8'h22);
        push_byte(8'h11);
        push_byte(8'h22);
        qread(24'h3FFFFF, 4);
        push_byte(8'h22);
        qread(24'h000000, 2);

        // 5: abort mid-byte leaves the next location untouched
        qwrite(24'h000021, 8'h5A, 8'h00);
        hdr(CMD_QWRITE, 24'h000020);
        nib(4'h7, 4'h0, "wr", s);
        nib(4'hE, 4'h0, "wr", s);
        nib(4'h9, 4'h0, "wr", s);
        txn_end();
        push_byte(8'h7E);
        push_byte(8'h5A);
        qread(24'h000020, 4);

        // 5b: unknown command is ignored
        qspi_ce_n = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] c;
            c = 8'h9F;
            nib({3'b000, c[i]}, 4'h0, "badcmd", s);
        end
        for (int i = 0; i < 8; i++) nib(4'hF, 4'h0, "ignore", s);
        chk("ignore_state", {1'b0, dut.state_q}, {1'b0, S_IGNORE});
        txn_end();

        // 6: reset during read data
        push_byte(8'hA5);
        hdr(CMD_QREAD, 24'h000010);
        dummy_phase();
        read_nibs(2);
        #40;
        chk("pre_rst_en", qspi_douten, 4'hF);
        resetn = 1'b0;
        #1;
        chk("async_rst_en", qspi_douten, 4'h0);
        chk("async_rst_dout", qspi_dout, 4'h0);
        qspi_ce_n = 1'b1;
        m_dio     = 4'h0;
        #50;
        resetn = 1'b1;
        #100;
        push_byte(8'h3C);
        qread(24'h000011, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
